// File: rtl/video_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : video_ctrl_pkg                                            |
// | Purpose  : Shared command/response byte codes and state encodings    |
// |            for the serial video control block.                       |
// | Contents : CMD_START, CMD_STOP, CMD_COLOR, RSP_ACK, RSP_NAK,          |
// |            parse_state_t (command parser), rx_state_t (UART RX).     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package video_ctrl_pkg;

   localparam logic [7:0] CMD_START = 8'h53;  // 'S' : enable video
   localparam logic [7:0] CMD_STOP  = 8'h58;  // 'X' : disable video
   localparam logic [7:0] CMD_COLOR = 8'h43;  // 'C' : R, G, B bytes follow
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GET_R = 2'd1,
      ST_GET_G = 2'd2,
      ST_GET_B = 2'd3
   } parse_state_t;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_8n1                                               |
// | Purpose  : 8N1 UART receiver with 2-FF input synchronizer, mid-bit   |
// |            sampling, false-start rejection and framing check.        |
// | Ports    : clk        in  clock                                      |
// |            reset_n    in  asynchronous active-low reset              |
// |            rx         in  serial input, idle high, asynchronous      |
// |            byte_valid out one-cycle strobe for a well-framed byte    |
// |            data       out received byte, valid with byte_valid       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_rx_8n1
   import video_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] data
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   rx_state_t     state;
   logic [CW-1:0] tick;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RX_IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state <= RX_START;
                  tick  <= '0;
               end
            end
            RX_START: begin
               // Half a bit in: a line back high means a glitch, not a start bit.
               if (tick == HALF_TICK) begin
                  tick <= '0;
                  if (rx_sync) begin
                     state <= RX_IDLE;
                  end else begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            RX_DATA: begin
               if (tick == LAST_TICK) begin
                  tick  <= '0;
                  shift <= {rx_sync, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= RX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            RX_STOP: begin
               if (tick == LAST_TICK) begin
                  tick <= '0;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     data       <= shift;
                     state      <= RX_IDLE;
                  end else begin
                     // Framing error: drop the byte and re-arm only once the
                     // line has returned to idle.
                     state <= RX_WAIT_HIGH;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_sync) begin
                  state <= RX_IDLE;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_video_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_video_ctrl                                         |
// | Purpose  : UART command interface for the HDMI output path: video    |
// |            enable, solid fill colour, ACK/NAK responses on TX.       |
// | Ports    : clk      in  pixel clock                                  |
// |            reset_n  in  asynchronous active-low reset                |
// |            rx       in  UART from host, idle high                    |
// |            tx       out UART to host, idle high                      |
// |            tx_busy  out response frame on the line                   |
// |            vid_en   out video enable (HDMI reset release)            |
// |            fill_r/g/b out 8 solid fill colour                        |
// |            led      out 8 last well-framed byte received             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module serial_video_ctrl
   import video_ctrl_pkg::*;
#(
   parameter int CLK_HZ       = 25_000_000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_CLKS = 2_500_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic       tx,
   output logic       tx_busy,
   output logic       vid_en,
   output logic [7:0] fill_r,
   output logic [7:0] fill_g,
   output logic [7:0] fill_b,
   output logic [7:0] led
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TCW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
   localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CLKS - 1);

   logic         byte_valid;
   logic [7:0]   rx_data;

   uart_rx_8n1 #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .byte_valid (byte_valid),
      .data       (rx_data)
   );

   // ---------------------------------------------------------------- parser
   parse_state_t   pstate;
   logic [TCW-1:0] tmo_cnt;
   logic [7:0]     shadow_r;
   logic [7:0]     shadow_g;
   logic           rsp_valid;
   logic [7:0]     rsp_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pstate    <= ST_IDLE;
         tmo_cnt   <= '0;
         shadow_r  <= '0;
         shadow_g  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         vid_en    <= 1'b0;
         fill_r    <= '0;
         fill_g    <= '0;
         fill_b    <= '0;
         led       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (byte_valid) begin
            led <= rx_data;
         end
         case (pstate)
            ST_IDLE: begin
               if (byte_valid) begin
                  case (rx_data)
                     CMD_START: begin
                        vid_en    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= RSP_ACK;
                     end
                     CMD_STOP: begin
                        vid_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= RSP_ACK;
                     end
                     CMD_COLOR: begin
                        pstate  <= ST_GET_R;
                        tmo_cnt <= '0;
                     end
                     default: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= RSP_NAK;
                     end
                  endcase
               end
            end
            ST_GET_R, ST_GET_G, ST_GET_B: begin
               if (byte_valid) begin
                  tmo_cnt <= '0;
                  if (pstate == ST_GET_R) begin
                     shadow_r <= rx_data;
                     pstate   <= ST_GET_G;
                  end else if (pstate == ST_GET_G) begin
                     shadow_g <= rx_data;
                     pstate   <= ST_GET_B;
                  end else begin
                     // All three channels change on the same edge so the
                     // pixel mux never shows a mixed colour.
                     fill_r    <= shadow_r;
                     fill_g    <= shadow_g;
                     fill_b    <= rx_data;
                     rsp_valid <= 1'b1;
                     rsp_data  <= RSP_ACK;
                     pstate    <= ST_IDLE;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // This cycle is the TIMEOUT_CLKS-th idle clock.
                  rsp_valid <= 1'b1;
                  rsp_data  <= RSP_NAK;
                  shadow_r  <= '0;
                  shadow_g  <= '0;
                  tmo_cnt   <= '0;
                  pstate    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: pstate <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ TX shifter
   logic           pend_valid;
   logic [7:0]     pend_data;
   logic [BCW-1:0] tx_tick;
   logic [3:0]     tx_idx;
   logic [8:0]     tx_shift;

   logic           have_rsp;
   logic [7:0]     next_rsp;
   logic           bit_end;
   logic           frame_end;
   logic           launch;

   // A fresh response bypasses the pending register so an idle TX starts
   // on the very next cycle; a fresh one also supersedes anything pending.
   assign have_rsp  = rsp_valid | pend_valid;
   assign next_rsp  = rsp_valid ? rsp_data : pend_data;
   assign bit_end   = tx_busy && (tx_tick == BIT_LAST);
   assign frame_end = bit_end && (tx_idx == 4'd9);
   assign launch    = have_rsp && (!tx_busy || frame_end);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         tx_tick    <= '0;
         tx_idx     <= '0;
         tx_shift   <= '1;
      end else begin
         if (launch) begin
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            tx_shift   <= {1'b1, next_rsp};
            tx_tick    <= '0;
            tx_idx     <= '0;
            pend_valid <= 1'b0;
         end else begin
            if (rsp_valid) begin
               pend_valid <= 1'b1;
               pend_data  <= rsp_data;
            end
            if (frame_end) begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               tx_tick <= '0;
            end else if (bit_end) begin
               tx       <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_idx   <= tx_idx + 4'd1;
               tx_tick  <= '0;
            end else if (tx_busy) begin
               tx_tick <= tx_tick + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_video_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_video_ctrl                                      |
// | Purpose  : Directed self-checking bench for serial_video_ctrl with   |
// |            shortened bit period and timeout.                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_serial_video_ctrl;

   localparam int CLK_HZ = 160;
   localparam int BAUD   = 10;
   localparam int CPB    = 16;      // CLK_HZ / BAUD
   localparam int TMO    = 400;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       tx;
   logic       tx_busy;
   logic       vid_en;
   logic [7:0] fill_r;
   logic [7:0] fill_g;
   logic [7:0] fill_b;
   logic [7:0] led;

   serial_video_ctrl #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .tx      (tx),
      .tx_busy (tx_busy),
      .vid_en  (vid_en),
      .fill_r  (fill_r),
      .fill_g  (fill_g),
      .fill_b  (fill_b),
      .led     (led)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // TX frame decoder: records each byte and the cycle its start bit began.
   logic [7:0] mon_data [64];
   int         mon_start [64];
   int         mon_cnt = 0;
   bit         mon_en = 1'b1;
   int         m_st;
   logic [7:0] m_b;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && reset_n && tx === 1'b0) begin
            m_st = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               m_b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (mon_cnt < 64) begin
               mon_data[mon_cnt]  = m_b;
               mon_start[mon_cnt] = m_st;
            end
            mon_cnt++;
         end
      end
   end

   // Change stamps for led/fill and length of the last tx_busy pulse.
   logic [7:0]  led_q = 8'h00;
   logic [23:0] fill_q = 24'h0;
   int          led_chg = 0;
   int          fill_chg = 0;
   int          busy_run = 0;
   int          busy_len = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (led !== led_q) begin
            led_chg = cyc;
            led_q   = led;
         end
         if ({fill_r, fill_g, fill_b} !== fill_q) begin
            fill_chg = cyc;
            fill_q   = {fill_r, fill_g, fill_b};
         end
         if (tx_busy === 1'b1) begin
            busy_run++;
         end else if (busy_run > 0) begin
            busy_len = busy_run;
            busy_run = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_val = 1'b1,
                            input int stop_len = CPB);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_val;
      repeat (stop_len) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int t;
      t = 0;
      while (mon_cnt < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (mon_cnt < n) chk("wait_frames", mon_cnt, n);
   endtask

   int l_cyc;

   initial begin
      // ---------------- reset state
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_vid_en", vid_en, 0);
      chk("rst_fill", {fill_r, fill_g, fill_b}, 24'h000000);
      chk("rst_led", led, 8'h00);
      chk("rst_no_frames", mon_cnt, 0);

      // ---------------- 'S' : enable + ACK, latency
      send_byte(8'h53);
      wait_frames(1, 30 * CPB);
      chk("s_led", led, 8'h53);
      chk("s_vid_en", vid_en, 1);
      chk("s_ack", mon_data[0], 8'h06);
      chk("s_tx_latency", mon_start[0] - led_chg, 1);
      repeat (CPB) @(negedge clk);
      chk("tx_busy_len", busy_len, 10 * CPB);

      // ---------------- 'X' : disable + ACK
      send_byte(8'h58);
      wait_frames(2, 30 * CPB);
      chk("x_vid_en", vid_en, 0);
      chk("x_ack", mon_data[1], 8'h06);

      // ---------------- colour command, atomic update
      send_byte(8'h43);
      send_byte(8'h12);
      send_byte(8'h34);
      chk("c_led_g", led, 8'h34);
      chk("c_fill_before", {fill_r, fill_g, fill_b}, 24'h000000);
      send_byte(8'h56);
      chk("c_fill_after", {fill_r, fill_g, fill_b}, 24'h123456);
      chk("c_fill_cycle", fill_chg, led_chg);
      wait_frames(3, 30 * CPB);
      chk("c_ack", mon_data[2], 8'h06);
      repeat (20 * CPB) @(negedge clk);
      chk("c_one_rsp", mon_cnt, 3);

      // ---------------- colour timeout
      send_byte(8'h43);
      send_byte(8'hAA);
      l_cyc = led_chg;
      wait_frames(4, TMO + 30 * CPB);
      chk("t_nak", mon_data[3], 8'h15);
      // NAK issued TMO clocks after byte_valid, tx falls 2 after that;
      // led updates 1 after byte_valid.
      chk("t_delay", mon_start[3] - l_cyc, TMO + 1);
      chk("t_fill_kept", {fill_r, fill_g, fill_b}, 24'h123456);
      send_byte(8'h53);
      wait_frames(5, 30 * CPB);
      chk("t_after_ack", mon_data[4], 8'h06);
      chk("t_after_vid", vid_en, 1);

      // ---------------- unknown command
      send_byte(8'h41);
      wait_frames(6, 30 * CPB);
      chk("u_nak", mon_data[5], 8'h15);

      // ---------------- framing error
      send_byte(8'h77, 1'b0);
      repeat (20 * CPB) @(negedge clk);
      chk("f_led", led, 8'h41);
      chk("f_no_rsp", mon_cnt, 6);

      // ---------------- back-to-back: second response waits in pending
      send_byte(8'h53, 1'b1, CPB / 2 + 4);
      send_byte(8'h53);
      wait_frames(8, 40 * CPB);
      chk("b_ack1", mon_data[6], 8'h06);
      chk("b_ack2", mon_data[7], 8'h06);
      chk("b_no_gap", mon_start[7] - mon_start[6], 10 * CPB);

      // ---------------- asynchronous reset during a start bit
      mon_en = 1'b0;
      send_byte(8'h53);
      chk("r_tx_low", tx, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("r_tx", tx, 1);
      chk("r_tx_busy", tx_busy, 0);
      chk("r_vid_en", vid_en, 0);
      chk("r_fill", {fill_r, fill_g, fill_b}, 24'h000000);
      chk("r_led", led, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_video_ctrl.md
# serial_video_ctrl

Host-facing UART control block for the HDMI output path. It receives 8N1 command bytes from the FTDI link and drives the video enable into the HDMI transceiver's reset input. It also drives a solid fill colour into the pixel mux and acknowledges every command on the UART TX line. It runs entirely in the 25 MHz pixel clock domain.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000: clock frequency.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division; 217 at defaults).
- `TIMEOUT_CLKS`, 2_500_000: maximum gap between bytes of a multi-byte command (100 ms).

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx` in 1: UART input from `ftdi_txd`; idle high; asynchronous to `clk`.
- `tx` out 1: UART output to `ftdi_rxd`; idle high.
- `tx_busy` out 1: high while a response frame is on the line.
- `vid_en` out 1: video enable. The HDMI block is held in reset while this is low.
- `fill_r`, `fill_g`, `fill_b` out 8 each: solid fill colour.
- `led` out 8: last byte received without a framing error.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `vid_en`=0, `fill_*`=0, `led`=0, parser in IDLE, no pending response.
- RX path:
  - `rx` passes through a 2-FF synchronizer.
  - A high-to-low transition of the synchronized line while the receiver is idle starts a frame.
  - The start bit is re-checked at `CLKS_PER_BIT/2`. If it reads high, the start is false and the receiver returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT` clocks thereafter, LSB first.
  - The stop bit is sampled one bit period after the last data bit. If it reads 1, the frame produces a one-cycle `byte_valid` plus the data. If it reads 0 (framing error), the byte is discarded and the receiver waits for `rx` high before re-arming.
- Command parser states: IDLE, GET_R, GET_G, GET_B.
  - IDLE, 0x53 'S': `vid_en` := 1, respond ACK 0x06.
  - IDLE, 0x58 'X': `vid_en` := 0, respond ACK.
  - IDLE, 0x43 'C': go to GET_R, no response yet.
  - IDLE, any other byte: respond NAK 0x15, stay in IDLE.
  - GET_R and GET_G: store the byte in a shadow register and advance.
  - GET_B: load all three `fill_*` outputs from the shadow registers and the B byte in the same cycle (atomic update), respond ACK, return to IDLE.
  - In GET_R, GET_G or GET_B, `TIMEOUT_CLKS` clocks with no `byte_valid`: respond NAK, discard the shadow registers, return to IDLE. `fill_*` are unchanged.
- `led` is updated on every `byte_valid`, in all states.
- TX path:
  - 8N1 frame, `CLKS_PER_BIT` clocks per bit.
  - One-deep pending-response register. A response issued while TX is idle starts on the next cycle. A response issued while TX is busy is held and starts the cycle after the current stop bit ends.
  - A second response issued while one is already pending overwrites it. This cannot occur at the configured rates and is covered only as a boundary check.

## Timing
- `byte_valid` is asserted on the cycle the stop bit is sampled: (9.5·`CLKS_PER_BIT` + 2) clocks after the `rx` falling edge, ±1.
- `vid_en`, `fill_*` and `led` update one clock after `byte_valid`.
- `tx` falls (start bit) two clocks after `byte_valid` when TX is idle.
- `tx_busy` goes high with the start bit and low after exactly 10·`CLKS_PER_BIT` clocks.
- Timeout counter: cleared on entry to GET_R and on every `byte_valid`; NAK issued on the cycle the count reaches `TIMEOUT_CLKS`.
- Counter widths use `$clog2` of their maximum value.
- Reset mid-frame immediately returns all outputs to their reset values, including `tx`=1, even mid-bit.

## Structure
- Shared package `video_ctrl_pkg` holds:
  - Command and response byte constants: `CMD_START`, `CMD_STOP`, `CMD_COLOR`, `RSP_ACK`, `RSP_NAK`.
  - The parser state enum.
- One sub-module, `uart_rx_8n1`, containing the synchronizer, bit timing, framing check, and `byte_valid`/`data` outputs.
- The TX shifter and parser stay in the top module.

## Test plan
- Reset, then no activity → `tx`=1, `vid_en`=0, `fill_*`=0, `led`=0.
- Send 0x53 → `vid_en` 1 one clock after `byte_valid`, `led`=0x53, `tx` carries 0x06. Send 0x58 → `vid_en` 0, ACK.
- Send 0x43, 0x12, 0x34, 0x56 back-to-back → `fill_*` read 0x00/0x00/0x00 until the 0x56 byte completes, then change to 0x12/0x34/0x56 in the same cycle. One ACK on `tx`.
- Send 0x43, 0xAA, then silence → NAK 0x15 exactly `TIMEOUT_CLKS` clocks after the 0xAA `byte_valid`. `fill_*` unchanged; a following 0x53 is accepted.
- Send 0x41 → NAK. Send a frame with stop bit 0 → no `byte_valid`, `led` unchanged, no response.
- Send 0x53, 0x53 back-to-back → two ACK frames with no gap between the first stop bit and the second start bit. Drop `reset_n` mid-TX → `tx`=1 immediately.
